// File: rtl/camera_ctrl_if.sv
// -----------------------------------------------------------------------------
// camera_ctrl_if
//
// Purpose:
//    Bundles the signals between the user-input side and the frame-sequencing
//    controller. The user side owns the frame request and the exposure value.
//    The controller owns the pixel-array strobes, the ADC strobe and busy.
//
// Signals:
//    init      frame request (user -> controller)
//    exp_time  exposure length in clk cycles, EXP_W bits (user -> controller)
//    cont      continuous-mode request; exists only when the macro
//              CAMERA_CTRL_CONTINUOUS_EN is defined (user -> controller)
//    erase     pixel erase, high while idle
//    expose    exposure window
//    nre_1     read enable for row pair 1, active-low
//    nre_2     read enable for row pair 2, active-low
//    adc       ADC conversion strobe
//    busy      high while a frame is in progress
//
// Modports:
//    master  user-input side (drives init/exp_time/cont)
//    slave   camera_ctrl side (drives the array/ADC strobes and busy)
// -----------------------------------------------------------------------------
interface camera_ctrl_if #(
    parameter int EXP_W = 5
);
    logic             init;
    logic [EXP_W-1:0] exp_time;
`ifdef CAMERA_CTRL_CONTINUOUS_EN
    logic             cont;
`endif
    logic             erase;
    logic             expose;
    logic             nre_1;
    logic             nre_2;
    logic             adc;
    logic             busy;

    modport master (
`ifdef CAMERA_CTRL_CONTINUOUS_EN
        output cont,
`endif
        output init,
        output exp_time,
        input  erase,
        input  expose,
        input  nre_1,
        input  nre_2,
        input  adc,
        input  busy
    );

    modport slave (
`ifdef CAMERA_CTRL_CONTINUOUS_EN
        input  cont,
`endif
        input  init,
        input  exp_time,
        output erase,
        output expose,
        output nre_1,
        output nre_2,
        output adc,
        output busy
    );
endinterface

// File: rtl/camera_ctrl.sv
// -----------------------------------------------------------------------------
// camera_ctrl
//
// Purpose:
//    Frame-sequencing controller for the pixel array. A frame request taken in
//    IDLE runs one capture frame: exposure of N cycles, then two readout
//    phases (row pair 1, then row pair 2) of READ_LEN cycles each, with the
//    ADC strobe high on the inner cycles of each readout phase. N is the
//    exposure value sampled at the start edge, replaced by EXP_DEF when it
//    lies outside EXP_MIN..EXP_MAX.
//
// Ports:
//    clk    clock
//    reset  synchronous, active-high reset
//    bus    camera_ctrl_if slave modport (init, exp_time, [cont] in;
//           erase, expose, nre_1, nre_2, adc, busy out)
//
// Configuration:
//    CAMERA_CTRL_CONTINUOUS_EN  when defined, cont=1 in IDLE starts a frame
//                               just like init, so holding cont high gives
//                               back-to-back frames with one erase cycle
//                               between them.
//
// All outputs are registered and change together with the state register,
// so they are a pure function of the current state and phase.
// -----------------------------------------------------------------------------
module camera_ctrl #(
    parameter int EXP_W    = 5,
    parameter int EXP_MIN  = 2,
    parameter int EXP_MAX  = 30,
    parameter int EXP_DEF  = 15,
    parameter int READ_LEN = 3
) (
    input logic          clk,
    input logic          reset,
    camera_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXPOSE,
        READ1,
        READ2
    } state_t;

    localparam logic [EXP_W-1:0] MIN_V     = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] MAX_V     = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0] DEF_V     = EXP_W'(EXP_DEF);
    localparam logic [EXP_W-1:0] READ_LAST = EXP_W'(READ_LEN - 1);
    localparam logic [EXP_W-1:0] ADC_LAST  = EXP_W'(READ_LEN - 2);

    state_t           state;
    logic [EXP_W-1:0] count;
    logic             erase_q;
    logic             expose_q;
    logic             nre_1_q;
    logic             nre_2_q;
    logic             adc_q;
    logic             busy_q;

    logic             start;
    logic [EXP_W-1:0] n_sel;
    logic [EXP_W-1:0] phase_next;
    logic             adc_next;

    // Start condition, exposure clamp and readout phase decode.
    // The count register doubles as the exposure down-counter and as the
    // readout phase counter; phase_next is the phase the next edge enters,
    // so adc can be registered in step with it and rise one cycle after the
    // read enable falls and drop one cycle before it rises.
    always_comb begin
        start = bus.init;
`ifdef CAMERA_CTRL_CONTINUOUS_EN
        start = bus.init | bus.cont;
`endif
        n_sel = bus.exp_time;
        if ((bus.exp_time < MIN_V) || (bus.exp_time > MAX_V)) begin
            n_sel = DEF_V;
        end
        phase_next = count + 1'b1;
        adc_next   = (phase_next != '0) && (phase_next <= ADC_LAST);
    end

    // Frame sequencer with registered Moore outputs.
    // The exposure counter is loaded with N-1 at the start edge so that the
    // exposure window lasts exactly N cycles. Each readout phase counts
    // 0..READ_LEN-1 and hands over on the last phase cycle. A reset at any
    // point abandons the frame and restores the idle outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            erase_q  <= 1'b1;
            expose_q <= 1'b0;
            nre_1_q  <= 1'b1;
            nre_2_q  <= 1'b1;
            adc_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= EXPOSE;
                        count    <= n_sel - 1'b1;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                EXPOSE: begin
                    if (count == '0) begin
                        state    <= READ1;
                        expose_q <= 1'b0;
                        nre_1_q  <= 1'b0;
                        adc_q    <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                READ1: begin
                    if (count == READ_LAST) begin
                        state   <= READ2;
                        count   <= '0;
                        nre_1_q <= 1'b1;
                        nre_2_q <= 1'b0;
                        adc_q   <= 1'b0;
                    end else begin
                        count <= phase_next;
                        adc_q <= adc_next;
                    end
                end
                READ2: begin
                    if (count == READ_LAST) begin
                        state   <= IDLE;
                        count   <= '0;
                        nre_2_q <= 1'b1;
                        adc_q   <= 1'b0;
                        erase_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        count <= phase_next;
                        adc_q <= adc_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.erase  = erase_q;
    assign bus.expose = expose_q;
    assign bus.nre_1  = nre_1_q;
    assign bus.nre_2  = nre_2_q;
    assign bus.adc    = adc_q;
    assign bus.busy   = busy_q;

endmodule

// File: doc/camera_ctrl.md
# camera_ctrl

Frame-sequencing controller for the pixel array: on an `init` request it runs one capture frame (erase, expose, two row-pair readouts with ADC conversion) using the exposure length held by the exposure register. It is the consumer of the 5-bit exposure value (legal range 2..30 cycles, default 15). It drives the array control strobes and the ADC start signal. It sits between the user-input logic and the analog pixel array / ADC interface.

## Interface
- `EXP_W`, 5: exposure value width.
- `EXP_MIN`, 2: smallest legal exposure (cycles).
- `EXP_MAX`, 30: largest legal exposure (cycles).
- `EXP_DEF`, 15: exposure used when the sampled value is out of range.
- `READ_LEN`, 3: cycles per readout phase (must be >= 3).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `init`  in  1  frame request; sampled only in IDLE.
- `exp_time`  in  EXP_W  exposure length in clk cycles.
- `erase`  out  1  pixel erase, high in IDLE.
- `expose`  out  1  exposure window.
- `nre_1`  out  1  read enable, row pair 1, active-low.
- `nre_2`  out  1  read enable, row pair 2, active-low.
- `adc`  out  1  ADC conversion strobe.
- `busy`  out  1  high whenever state != IDLE.
- `cont`  in  1  continuous-mode request; present only with CAMERA_CTRL_CONTINUOUS_EN.

## Operation
- States: IDLE, EXPOSE, READ1, READ2. All outputs are registered and decoded from state only (Moore).
- Reset value of every output (IDLE): erase=1, expose=0, nre_1=1, nre_2=1, adc=0, busy=0. The internal counter resets to 0.
- IDLE -> EXPOSE when `init`=1.
  - `exp_time` is latched at this edge.
  - If the latched value is < EXP_MIN or > EXP_MAX, N = EXP_DEF; otherwise N = exp_time.
  - Changes on `exp_time` after the latch have no effect until the next frame.
- EXPOSE: erase=0, expose=1. A down-counter loaded with N-1 runs; at 0 the FSM goes to READ1.
- READ1: nre_1=0 for all READ_LEN cycles. adc=1 on phase cycles 1..READ_LEN-2. After READ_LEN cycles the FSM goes to READ2.
- READ2: identical to READ1, using nre_2 instead of nre_1. After READ_LEN cycles the FSM goes to IDLE.
- `init` outside IDLE is ignored; no queuing.
- nre_1 and nre_2 are never low simultaneously. expose and erase are never high simultaneously.
- Reset in any state: IDLE with reset outputs at the next edge. Any frame in progress is abandoned.
- Counter width is EXP_W. Arithmetic is unsigned, and no wrap is reachable with clamped N.

## Timing
- Let `init`=1 be sampled at edge E0 in IDLE.
  - expose=1 and busy=1 from E0 to E0+N (exactly N cycles).
  - READ1 from E0+N to E0+N+READ_LEN.
  - READ2 from E0+N+READ_LEN to E0+N+2·READ_LEN.
  - IDLE (erase=1, busy=0) from E0+N+2·READ_LEN.
- busy is high for N+2·READ_LEN cycles per frame.
- The earliest next frame is accepted at edge E0+N+2·READ_LEN+1, which guarantees at least one erase cycle.
- adc rises one cycle after nre_x falls and drops one cycle before nre_x rises.
- `init` held high continuously yields back-to-back frames separated by exactly one IDLE cycle.

## Configuration
- Macro: `CAMERA_CTRL_CONTINUOUS_EN`.
- Defined:
  - The `cont` input exists.
  - In IDLE, `cont`=1 acts as `init`, with `exp_time` re-sampled each frame.
  - Deasserting `cont` mid-frame completes the current frame, then the block stays in IDLE.
  - `init` still works as before.
- Undefined: no `cont` port; frames start only on `init`.

## Test plan
- Reset, then `exp_time`=2 with a 1-cycle `init` -> expose high 2 cycles; nre_1 low 3 cycles with adc high in the middle cycle; same for nre_2; busy high 8 cycles; erase=1 afterwards.
- `exp_time`=30 -> expose high exactly 30 cycles; busy 36 cycles. `exp_time`=0 and `exp_time`=31 -> expose 15 cycles each.
- `exp_time` changed from 5 to 20 during EXPOSE -> that frame still exposes 5 cycles; the next frame exposes 20.
- `init` pulsed during EXPOSE and during READ2 -> ignored; only one frame occurs.
- `reset` asserted at exposure cycle 3 of 10 -> next edge returns all outputs to reset values. A fresh `init` then runs a full 10-cycle exposure.
- With CAMERA_CTRL_CONTINUOUS_EN, `cont` held high and `exp_time`=4 -> repeated 10-cycle frames each separated by one erase cycle. Dropping `cont` mid-READ1 -> the frame finishes, then the block stays IDLE.
